uart_packet_rx: RTL and testbench
=================================

// Module: uart_packet_rx
// PURPOSE
//  Parametrised UART packet receiver; successor to the fixed 4-byte header/payload receiver.
//  Decodes one header frame carrying rw, memory type, burst length and start address.
//  Write packets: assembles 1..2^LEN_W payload words with a valid/ready handshake.
//  Adds inter-frame timeout, frame-error and overrun detection. Sits between the rx pin and the memory-load arbiter.
// PARAMETERS
//  CLKS_PER_BIT  434  clk cycles per UART bit (115200 baud @ 50 MHz)
//  DATA_BITS     16   bits per UART frame; must equal 2+MT_W+LEN_W+ADDR_W
//  MT_W          1    memory-type field width
//  LEN_W         4    burst-length field width (field value = words-1)
//  ADDR_W        9    start-address field width
//  WORD_BYTES    4    payload bytes per word (word width = 8*WORD_BYTES)
//  TIMEOUT_CLKS  8*DATA_BITS*CLKS_PER_BIT  max idle clk cycles between frames inside a packet
// PORTS
//  clk        in   1             clock clk
//  reset      in   1             reset reset, asynchronous, active-high
//  rx         in   1             UART serial input, idle high
//  hdr_valid  out  1             1-cycle pulse: header accepted, fields below valid
//  rw         out  1             1=write, 0=read
//  mem_type   out  MT_W          target memory type
//  burst_len  out  LEN_W         words-1 of the packet
//  word_addr  out  ADDR_W        address of the word currently on word_data
//  word_data  out  8*WORD_BYTES  assembled payload word, first byte in MSBs
//  word_valid out  1             payload word available
//  word_ready in   1             consumer accepts word when word_valid&&word_ready
//  word_last  out  1             word_valid qualifier: final word of burst
//  pkt_done   out  1             1-cycle pulse: packet completed without error
//  err        out  1             1-cycle pulse: packet aborted
//  err_code   out  2             01 frame(stop=0), 10 timeout, 11 overrun; holds until next err
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, counters 0. Reset mid-packet discards the packet with no err pulse.
//  Header frame bits (MSB->LSB): rw | sync | mem_type | len | addr. sync must be 1, else the frame is dropped with no err.
//  Payload frames: only bits [7:0] are used; upper bits are ignored.
//  FSM:
//   IDLE: on frame done -> header check. Valid write -> PAYLOAD; valid read -> DONE. hdr_valid pulses the cycle after frame done.
//   PAYLOAD: counts bytes; after WORD_BYTES bytes, word_valid=1 the next cycle.
//    word_addr = start+word_idx mod 2^ADDR_W (wraps). After the last word is accepted -> DONE (or CHECK).
//   CHECK: one extra frame with XOR of all payload bytes (CHECKSUM_EN only). Mismatch -> err, code 01.
//   DONE: pkt_done=1 for one cycle -> IDLE.
//  Handshake: word_data/word_addr/word_last stay stable while word_valid&&!word_ready.
//  A new word completing while the previous word is unaccepted -> overrun: err=11, drop, IDLE.
//  Accept and new completion in the same cycle is legal and loads the new word.
//  Timeout counter runs only outside IDLE, restarts on each rx falling edge. Reaching TIMEOUT_CLKS -> err=10, IDLE.
//  Frame error from the deserialiser outside IDLE -> err=01, IDLE. In IDLE the frame is silently dropped.
//  Error pulse and pkt_done are never asserted in the same cycle.
// CONFIGURATION
//  UART_PKT_CHECKSUM_EN defined: write packets carry a trailing checksum frame.
//   pkt_done asserts only after a match. A read packet has no checksum.
//  Undefined: no CHECK state; pkt_done follows last word acceptance; err_code 01 means only a stop-bit error.
// STRUCTURE
//  Package uart_pkt_pkg: state encoding, err_code constants, header field offset localparams.
//  Sub-module uart_frame_rx: 2-FF rx synchroniser, mid-bit sampling, DATA_BITS shift register.
//   Outputs frame_data, frame_done pulse, frame_err.
// TESTING
//  Write hdr 16'hC0A5 (rw=1,mt=0,len=0,addr=0x0A5) + bytes 12 34 56 78, ready=1
//   -> one word 0x12345678, addr 0x0A5, last=1, then pkt_done.
//  Read hdr 16'h6010 -> hdr_valid rw=0 mt=1 addr=0x010, pkt_done next cycle, no word_valid.
//  Write len=1 addr=0x1FF, 8 bytes -> words at 0x1FF then 0x000 (wrap), last on second only.
//  word_ready held 0 through two full words -> err_code=11 when second word completes, FSM IDLE.
//  Header then rx idle high for TIMEOUT_CLKS -> err_code=10. Reset asserted mid-byte -> outputs 0, no err.
//  CHECKSUM_EN: correct XOR -> pkt_done; XOR^1 -> err_code=01, no pkt_done.

Source files
------------

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet receiver: FSM encoding, error codes
// and header field positions.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_FRAME   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

  // rw and sync are counted down from the frame MSB; the remaining fields
  // are packed upward from the address at bit 0.
  localparam int HDR_RW_FROM_MSB   = 0;
  localparam int HDR_SYNC_FROM_MSB = 1;
  localparam int HDR_ADDR_LSB      = 0;

endpackage

// File: rtl/uart_frame_rx.sv
// UART frame deserialiser: 2-FF synchroniser, mid-bit sampling, LSB-first
// shift register. Emits a one-cycle frame_done with frame_err for a low stop bit.
module uart_frame_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] frame_data,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic                 rx_fall
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 2);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_RELOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] STOP_IDX    = IDX_W'(DATA_BITS + 1);

  logic                 rx_meta, rx_sync, rx_prev;
  logic                 busy;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // bit_idx 0 is the start bit (re-checked at mid-bit to reject glitches),
  // 1..DATA_BITS are data bits, DATA_BITS+1 is the stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy       <= 1'b0;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      frame_data <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (!busy) begin
        if (rx_fall) begin
          busy    <= 1'b1;
          clk_cnt <= HALF_RELOAD;
          bit_idx <= '0;
        end
      end else if (clk_cnt != '0) begin
        clk_cnt <= clk_cnt - CNT_W'(1);
      end else begin
        clk_cnt <= BIT_RELOAD;
        if (bit_idx == '0) begin
          if (rx_sync) busy <= 1'b0;
          else         bit_idx <= IDX_W'(1);
        end else if (bit_idx == STOP_IDX) begin
          busy       <= 1'b0;
          frame_done <= 1'b1;
          frame_err  <= ~rx_sync;
          frame_data <= shreg;
        end else begin
          shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
          bit_idx <= bit_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/uart_packet_rx.sv
// UART packet receiver: header decode, payload word assembly with valid/ready,
// timeout/frame/overrun errors. Define UART_PKT_CHECKSUM_EN for a trailing XOR checksum frame.
module uart_packet_rx
  import uart_pkt_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 16,
  parameter int MT_W         = 1,
  parameter int LEN_W        = 4,
  parameter int ADDR_W       = 9,
  parameter int WORD_BYTES   = 4,
  parameter int TIMEOUT_CLKS = 8 * DATA_BITS * CLKS_PER_BIT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  output logic                    hdr_valid,
  output logic                    rw,
  output logic [MT_W-1:0]         mem_type,
  output logic [LEN_W-1:0]        burst_len,
  output logic [ADDR_W-1:0]       word_addr,
  output logic [8*WORD_BYTES-1:0] word_data,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic                    word_last,
  output logic                    pkt_done,
  output logic                    err,
  output logic [1:0]              err_code
);

  localparam int WORD_W   = 8 * WORD_BYTES;
  localparam int LEN_LSB  = HDR_ADDR_LSB + ADDR_W;
  localparam int MT_LSB   = LEN_LSB + LEN_W;
  localparam int SYNC_BIT = DATA_BITS - 1 - HDR_SYNC_FROM_MSB;
  localparam int RW_BIT   = DATA_BITS - 1 - HDR_RW_FROM_MSB;
  localparam int BC_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TO_W     = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_BYTES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

`ifdef UART_PKT_CHECKSUM_EN
  localparam state_t AFTER_LAST = ST_CHECK;
`else
  localparam state_t AFTER_LAST = ST_DONE;
`endif

  logic [DATA_BITS-1:0] frame_data;
  logic                 frame_done, frame_err, rx_fall;
  state_t               state, next_state;
  logic [ADDR_W-1:0]    start_addr;
  logic [LEN_W-1:0]     word_idx;
  logic [BC_W-1:0]      byte_cnt;
  logic [WORD_W-1:0]    asm_data, asm_next;
  logic [TO_W-1:0]      to_cnt;
  logic                 all_in;
  logic                 in_pkt, frame_ok, hdr_ok, pay_byte, word_cmp, accept;
  logic                 frame_bad, overrun, timeout, chk_bad, abort;
  logic [1:0]           abort_code;

  uart_frame_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS)
  ) u_frame_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .frame_data(frame_data),
    .frame_done(frame_done),
    .frame_err (frame_err),
    .rx_fall   (rx_fall)
  );

  assign in_pkt    = (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign frame_ok  = frame_done & ~frame_err;
  assign hdr_ok    = (state == ST_IDLE) & frame_ok & frame_data[SYNC_BIT];
  assign pay_byte  = (state == ST_PAYLOAD) & frame_ok & ~all_in;
  assign word_cmp  = pay_byte & (byte_cnt == BC_LAST);
  assign accept    = word_valid & word_ready;
  assign frame_bad = in_pkt & frame_done & frame_err;
  assign overrun   = word_cmp & word_valid & ~word_ready;
  assign timeout   = in_pkt & (to_cnt == TO_LAST);
  assign abort     = frame_bad | chk_bad | overrun | timeout;

  generate
    if (WORD_BYTES > 1) begin : g_asm_multi
      assign asm_next = {asm_data[WORD_W-9:0], frame_data[7:0]};
    end else begin : g_asm_single
      assign asm_next = frame_data[7:0];
    end
  endgenerate

  always_comb begin
    abort_code = ERR_NONE;
    if (frame_bad || chk_bad) abort_code = ERR_FRAME;
    else if (overrun)         abort_code = ERR_OVERRUN;
    else if (timeout)         abort_code = ERR_TIMEOUT;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:    if (hdr_ok) next_state = ST_HDR;
      ST_HDR:     next_state = rw ? ST_PAYLOAD : ST_DONE;
      ST_PAYLOAD: if (abort) next_state = ST_IDLE;
                  else if (accept && word_last) next_state = AFTER_LAST;
      ST_CHECK:   if (abort) next_state = ST_IDLE;
                  else if (frame_ok) next_state = ST_DONE;
      ST_DONE:    next_state = ST_IDLE;
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    hdr_valid = (state == ST_HDR);
    pkt_done  = (state == ST_DONE);
  end

  // Idle time is measured from the last rx falling edge while a packet is open.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            to_cnt <= '0;
    else if (state == ST_IDLE || rx_fall) to_cnt <= '0;
    else if (to_cnt != TO_LAST)           to_cnt <= to_cnt + TO_W'(1);
  end

`ifdef UART_PKT_CHECKSUM_EN
  logic [7:0] chk;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         chk <= '0;
    else if (hdr_ok)   chk <= '0;
    else if (pay_byte) chk <= chk ^ frame_data[7:0];
  end

  assign chk_bad = (state == ST_CHECK) & frame_ok & (frame_data[7:0] != chk);
`else
  assign chk_bad = 1'b0;
`endif

  // After the last word completes, further payload frames are ignored until it is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rw         <= 1'b0;
      mem_type   <= '0;
      burst_len  <= '0;
      start_addr <= '0;
      word_addr  <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_idx   <= '0;
      byte_cnt   <= '0;
      asm_data   <= '0;
      all_in     <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      err <= abort;
      if (abort) err_code <= abort_code;
      if (hdr_ok) begin
        rw         <= frame_data[RW_BIT];
        mem_type   <= frame_data[MT_LSB +: MT_W];
        burst_len  <= frame_data[LEN_LSB +: LEN_W];
        start_addr <= frame_data[HDR_ADDR_LSB +: ADDR_W];
        word_addr  <= frame_data[HDR_ADDR_LSB +: ADDR_W];
        word_idx   <= '0;
        byte_cnt   <= '0;
        all_in     <= 1'b0;
      end
      if (pay_byte) begin
        asm_data <= asm_next;
        byte_cnt <= word_cmp ? '0 : byte_cnt + BC_W'(1);
      end
      if (abort) begin
        word_valid <= 1'b0;
      end else if (word_cmp) begin
        word_valid <= 1'b1;
        word_data  <= asm_next;
        word_addr  <= start_addr + ADDR_W'(word_idx);
        word_last  <= (word_idx == burst_len);
        word_idx   <= word_idx + LEN_W'(1);
        if (word_idx == burst_len) all_in <= 1'b1;
      end else if (accept) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_packet_rx.sv
// Directed self-checking bench for uart_packet_rx with a short bit period.
// Expected values are hand-computed from the packet format.
module tb_uart_packet_rx;

  localparam int CPB = 8;
  localparam int DB  = 16;

  logic        clk = 1'b0;
  logic        reset, rx, word_ready;
  logic        hdr_valid, rw, mem_type, word_valid, word_last, pkt_done, err;
  logic [3:0]  burst_len;
  logic [8:0]  word_addr;
  logic [31:0] word_data;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  int cyc = 0, hdr_cnt = 0, done_cnt = 0, err_cnt = 0, wv_cnt = 0, clash_cnt = 0;
  int hdr_cyc = 0, done_cyc = 0;
  logic        m_rw, m_mt;
  logic [3:0]  m_len;
  logic [8:0]  m_addr;
  logic [1:0]  m_code;
  logic [31:0] wd_q[$];
  logic [8:0]  wa_q[$];
  logic        wl_q[$];
  int h0, d0, e0, w0, v0;

  uart_packet_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .hdr_valid (hdr_valid),
    .rw        (rw),
    .mem_type  (mem_type),
    .burst_len (burst_len),
    .word_addr (word_addr),
    .word_data (word_data),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_last (word_last),
    .pkt_done  (pkt_done),
    .err       (err),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  // Records pulses and accepted words, sampled away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (hdr_valid) begin
      hdr_cnt++;
      hdr_cyc = cyc;
      m_rw = rw; m_mt = mem_type; m_len = burst_len; m_addr = word_addr;
    end
    if (pkt_done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; m_code = err_code; end
    if (err && pkt_done) clash_cnt++;
    if (word_valid) wv_cnt++;
    if (word_valid && word_ready) begin
      wd_q.push_back(word_data);
      wa_q.push_back(word_addr);
      wl_q.push_back(word_last);
    end
  end

  function automatic logic [31:0] qd(input int i);
    return (i < wd_q.size()) ? wd_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] qa(input int i);
    return (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] ql(input int i);
    return (i < wl_q.size()) ? 32'(wl_q[i]) : 32'hxxxxxxxx;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Sends one UART frame LSB first; called and returning at a falling edge.
  task automatic applyStimulus(input logic [15:0] frame, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic snap();
    h0 = hdr_cnt; d0 = done_cnt; e0 = err_cnt; w0 = wd_q.size(); v0 = wv_cnt;
  endtask

  initial begin
    reset = 1'b1; rx = 1'b1; word_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("rst_hdr_valid", 32'(hdr_valid), 0);
    checkOutput("rst_word_valid", 32'(word_valid), 0);
    checkOutput("rst_pkt_done", 32'(pkt_done), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_word_data", word_data, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    $display("[TB] single-word write");
    snap();
    applyStimulus(16'hC0A5, 1'b1);
    applyStimulus(16'hFF12, 1'b1);
    applyStimulus(16'h0034, 1'b1);
    applyStimulus(16'hA556, 1'b1);
    applyStimulus(16'h0078, 1'b1);
`ifdef UART_PKT_CHECKSUM_EN
    applyStimulus(16'h0008, 1'b1);
`endif
    repeat (10) @(negedge clk);
    checkOutput("w1_hdr_cnt", hdr_cnt - h0, 1);
    checkOutput("w1_rw", 32'(m_rw), 1);
    checkOutput("w1_mt", 32'(m_mt), 0);
    checkOutput("w1_len", 32'(m_len), 0);
    checkOutput("w1_hdr_addr", 32'(m_addr), 32'h0A5);
    checkOutput("w1_words", wd_q.size() - w0, 1);
    checkOutput("w1_data", qd(w0), 32'h12345678);
    checkOutput("w1_addr", qa(w0), 32'h0A5);
    checkOutput("w1_last", ql(w0), 1);
    checkOutput("w1_done", done_cnt - d0, 1);
    checkOutput("w1_err", err_cnt - e0, 0);

    $display("[TB] read header");
    snap();
    applyStimulus(16'h6010, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("rd_hdr_cnt", hdr_cnt - h0, 1);
    checkOutput("rd_rw", 32'(m_rw), 0);
    checkOutput("rd_mt", 32'(m_mt), 1);
    checkOutput("rd_addr", 32'(m_addr), 32'h010);
    checkOutput("rd_done", done_cnt - d0, 1);
    checkOutput("rd_done_lat", done_cyc - hdr_cyc, 1);
    checkOutput("rd_no_word", wv_cnt - v0, 0);

    $display("[TB] two-word write with address wrap");
    snap();
    applyStimulus(16'hC3FF, 1'b1);
    applyStimulus(16'h00AA, 1'b1);
    applyStimulus(16'h00BB, 1'b1);
    applyStimulus(16'h00CC, 1'b1);
    applyStimulus(16'h00DD, 1'b1);
    applyStimulus(16'h0011, 1'b1);
    applyStimulus(16'h0022, 1'b1);
    applyStimulus(16'h0033, 1'b1);
    applyStimulus(16'h0044, 1'b1);
`ifdef UART_PKT_CHECKSUM_EN
    applyStimulus(16'h0044, 1'b1);
`endif
    repeat (10) @(negedge clk);
    checkOutput("wr2_words", wd_q.size() - w0, 2);
    checkOutput("wr2_data0", qd(w0), 32'hAABBCCDD);
    checkOutput("wr2_addr0", qa(w0), 32'h1FF);
    checkOutput("wr2_last0", ql(w0), 0);
    checkOutput("wr2_data1", qd(w0 + 1), 32'h11223344);
    checkOutput("wr2_addr1", qa(w0 + 1), 32'h000);
    checkOutput("wr2_last1", ql(w0 + 1), 1);
    checkOutput("wr2_done", done_cnt - d0, 1);

    $display("[TB] overrun");
    word_ready = 1'b0;
    snap();
    applyStimulus(16'hC220, 1'b1);
    applyStimulus(16'h0001, 1'b1);
    applyStimulus(16'h0002, 1'b1);
    applyStimulus(16'h0003, 1'b1);
    applyStimulus(16'h0004, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("ovr_hold_valid", 32'(word_valid), 1);
    checkOutput("ovr_hold_data", word_data, 32'h01020304);
    checkOutput("ovr_hold_addr", 32'(word_addr), 32'h020);
    checkOutput("ovr_hold_last", 32'(word_last), 0);
    checkOutput("ovr_no_err_yet", err_cnt - e0, 0);
    applyStimulus(16'h0005, 1'b1);
    applyStimulus(16'h0006, 1'b1);
    applyStimulus(16'h0007, 1'b1);
    applyStimulus(16'h0008, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("ovr_err", err_cnt - e0, 1);
    checkOutput("ovr_code", 32'(m_code), 32'h3);
    checkOutput("ovr_code_hold", 32'(err_code), 32'h3);
    checkOutput("ovr_valid_drop", 32'(word_valid), 0);
    checkOutput("ovr_no_done", done_cnt - d0, 0);
    word_ready = 1'b1;
    snap();
    applyStimulus(16'h6010, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("ovr_idle_hdr", hdr_cnt - h0, 1);

    $display("[TB] timeout");
    snap();
    applyStimulus(16'hC0A5, 1'b1);
    repeat (500) @(negedge clk);
    checkOutput("to_early", err_cnt - e0, 0);
    repeat (700) @(negedge clk);
    checkOutput("to_err", err_cnt - e0, 1);
    checkOutput("to_code", 32'(m_code), 32'h2);
    checkOutput("to_no_done", done_cnt - d0, 0);

    $display("[TB] stop-bit error");
    snap();
    applyStimulus(16'hC0A5, 1'b1);
    applyStimulus(16'h0012, 1'b0);
    repeat (10) @(negedge clk);
    checkOutput("fe_err", err_cnt - e0, 1);
    checkOutput("fe_code", 32'(m_code), 32'h1);
    checkOutput("fe_no_done", done_cnt - d0, 0);

    $display("[TB] reset mid-byte");
    applyStimulus(16'hC0A5, 1'b1);
    snap();
    rx = 1'b0;
    repeat (4 * CPB) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("mr_rw", 32'(rw), 0);
    checkOutput("mr_err_code", 32'(err_code), 0);
    checkOutput("mr_word_valid", 32'(word_valid), 0);
    checkOutput("mr_hdr_valid", 32'(hdr_valid), 0);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5 * CPB) @(negedge clk);
    checkOutput("mr_no_err", err_cnt - e0, 0);

    $display("[TB] sync bit clear");
    snap();
    applyStimulus(16'h80A5, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("sync_drop", hdr_cnt - h0, 0);
    checkOutput("sync_no_err", err_cnt - e0, 0);
    applyStimulus(16'h6010, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("sync_then_rd", hdr_cnt - h0, 1);

`ifdef UART_PKT_CHECKSUM_EN
    $display("[TB] checksum mismatch");
    snap();
    applyStimulus(16'hC0A5, 1'b1);
    applyStimulus(16'h0012, 1'b1);
    applyStimulus(16'h0034, 1'b1);
    applyStimulus(16'h0056, 1'b1);
    applyStimulus(16'h0078, 1'b1);
    applyStimulus(16'h0009, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("ck_err", err_cnt - e0, 1);
    checkOutput("ck_code", 32'(m_code), 32'h1);
    checkOutput("ck_no_done", done_cnt - d0, 0);
`endif

    checkOutput("no_err_done_clash", clash_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
